// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD vector ALU: opcode encoding, default
// geometry and the lane slicing helper used when splitting packed rows.
// Optional build macro: SIMD_SATURATE_EN (saturating ADD/SUB in simd_lane).
package simd_pkg;

   localparam int DEF_ADDR_WIDTH   = 10;
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_NUM_ELEMENTS = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_MIN = 3'd6,
      OP_MAX = 3'd7
   } op_e;

   // Lane i of a packed row starts at bit i*width.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/simd_lane.sv
// One combinational element lane of the SIMD ALU. Computes op(a, b) on a
// single two's complement element; lanes never share carries.
// Optional build macro: SIMD_SATURATE_EN clamps ADD/SUB to the signed range
// instead of wrapping. MUL always keeps the low DATA_WIDTH product bits.
module simd_lane
   import simd_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)
(
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] add_res;
   logic [DATA_WIDTH-1:0] sub_res;

   assign sum  = a + b;
   assign diff = a - b;

`ifdef SIMD_SATURATE_EN
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic add_ovf;
   logic sub_ovf;

   // Overflow only when the operands push the result past the sign of a;
   // the clamp direction follows the sign of a.
   assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
   assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
   assign add_res = add_ovf ? (a[MSB] ? SAT_MIN : SAT_MAX) : sum;
   assign sub_res = sub_ovf ? (a[MSB] ? SAT_MIN : SAT_MAX) : diff;
`else
   assign add_res = sum;
   assign sub_res = diff;
`endif

   // Select the element result for the current opcode.
   always_comb begin
      result = '0;
      case (op_e'(op))
         OP_ADD:  result = add_res;
         OP_SUB:  result = sub_res;
         OP_MUL:  result = a * b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
         OP_MAX:  result = ($signed(a) < $signed(b)) ? b : a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/simd_vector_alu.sv
// SIMD vector ALU execution stage. Two-stage pipeline: S1 captures the
// operand rows, opcode and destination address; S2 captures the lane results.
// Valid/ready handshake on both sides; wr_en strobes the BRAM write exactly
// on the cycle a result row is taken by the store side.
// Optional build macro: SIMD_SATURATE_EN (saturating ADD/SUB lanes).
module simd_vector_alu
   import simd_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS
)
(
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [2:0]                         op,
   input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] row_a,
   input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] row_b,
   input  logic [ADDR_WIDTH-1:0]              addr_r_in,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] R,
   output logic [ADDR_WIDTH-1:0]              addr_r,
   output logic                               wr_en
);

   localparam int ROW_WIDTH = DATA_WIDTH * NUM_ELEMENTS;

   logic                  s1_valid;
   logic [2:0]            s1_op;
   logic [ROW_WIDTH-1:0]  s1_row_a;
   logic [ROW_WIDTH-1:0]  s1_row_b;
   logic [ADDR_WIDTH-1:0] s1_addr;

   logic                  s2_valid;
   logic [ROW_WIDTH-1:0]  s2_row;
   logic [ADDR_WIDTH-1:0] s2_addr;

   logic                  s1_en;
   logic                  s2_en;
   logic [ROW_WIDTH-1:0]  lane_result;

   // A stage may load when it is empty or its content moves on this cycle,
   // so ready ripples combinationally from out_ready back to in_ready.
   assign s2_en     = !s2_valid | out_ready;
   assign s1_en     = !s1_valid | s2_en;
   assign in_ready  = s1_en;
   assign out_valid = s2_valid;
   assign wr_en     = s2_valid & out_ready;
   assign R         = s2_row;
   assign addr_r    = s2_addr;

   for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
      simd_lane #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .op     (s1_op),
         .a      (s1_row_a[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
         .b      (s1_row_b[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
         .result (lane_result[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
      );
   end

   // S1: capture an accepted input; an empty slot still advances as a bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_row_a <= '0;
         s1_row_b <= '0;
         s1_addr  <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op    <= op;
            s1_row_a <= row_a;
            s1_row_b <= row_b;
            s1_addr  <= addr_r_in;
         end
      end
   end

   // S2: register lane results and address; held while the store side stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid <= 1'b0;
         s2_row   <= '0;
         s2_addr  <= '0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_row  <= lane_result;
            s2_addr <= s1_addr;
         end
      end
   end

endmodule

// File: tb/tb_simd_vector_alu.sv
// Testbench for simd_vector_alu (default geometry: 10-bit address, 4 x 32-bit
// lanes). A reference model computes each accepted row from the opcode rules
// with plain integer arithmetic; a negedge monitor compares every emitted row
// against the expected queue. Directed tests add literal expectations.
// Honours SIMD_SATURATE_EN for the saturating ADD/SUB expectations.
module tb_simd_vector_alu;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int NE = 4;
   localparam int RW = DW * NE;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic          clk       = 1'b0;
   logic          rstn      = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [2:0]    op        = '0;
   logic [RW-1:0] row_a     = '0;
   logic [RW-1:0] row_b     = '0;
   logic [AW-1:0] addr_r_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [RW-1:0] r_out;
   logic [AW-1:0] addr_r;
   logic          wr_en;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;

   typedef struct {
      logic [RW-1:0] row;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t exp_q[$];

   simd_vector_alu #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .NUM_ELEMENTS (NE)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .row_a     (row_a),
      .row_b     (row_b),
      .addr_r_in (addr_r_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (r_out),
      .addr_r    (addr_r),
      .wr_en     (wr_en)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Element result from the opcode rules, using signed integer arithmetic.
   function automatic logic [DW-1:0] model_lane(input logic [2:0] o, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
      int sa;
      int sb;
      longint ls;
      logic [DW-1:0] r;
      sa = a;
      sb = b;
      r  = '0;
      case (o)
         3'd0: begin
`ifdef SIMD_SATURATE_EN
            ls = longint'(sa) + longint'(sb);
            if (ls > SMAX) ls = SMAX;
            if (ls < SMIN) ls = SMIN;
            r = ls[31:0];
`else
            r = sa + sb;
`endif
         end
         3'd1: begin
`ifdef SIMD_SATURATE_EN
            ls = longint'(sa) - longint'(sb);
            if (ls > SMAX) ls = SMAX;
            if (ls < SMIN) ls = SMIN;
            r = ls[31:0];
`else
            r = sa - sb;
`endif
         end
         3'd2: r = sa * sb;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = (sa < sb) ? a : b;
         default: r = (sa < sb) ? b : a;
      endcase
      return r;
   endfunction

   function automatic logic [RW-1:0] model_row(input logic [2:0] o, input logic [RW-1:0] a,
                                               input logic [RW-1:0] b);
      logic [RW-1:0] r;
      r = '0;
      for (int l = 0; l < NE; l++)
         r[l*DW +: DW] = model_lane(o, a[l*DW +: DW], b[l*DW +: DW]);
      return r;
   endfunction

   function automatic logic [RW-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                           input logic [DW-1:0] l2, input logic [DW-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic checkOutput(input string name, input logic [RW-1:0] actual,
                              input logic [RW-1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present one row from posedge+1 and hold it until an edge accepts it.
   task automatic applyStimulus(input logic [2:0] o, input logic [RW-1:0] a,
                                input logic [RW-1:0] b, input logic [AW-1:0] ad);
      bit acc;
      op        = o;
      row_a     = a;
      row_b     = b;
      addr_r_in = ad;
      in_valid  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) return;
      end
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept timeout: addr 0x%0h never accepted, required acceptance", ad);
   endtask

   task automatic waitOut(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL out_valid timeout: got 0 for 8 cycles, required 1");
      end
   endtask

   // Scoreboard monitor: check emitted rows in order, count writes, record accepts.
   always @(negedge clk) begin
      exp_t e;
      if (wr_en) wr_count++;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected out_valid: got addr 0x%0h, required no row", addr_r);
         end else begin
            checkOutput("R row", r_out, exp_q[0].row);
            checkOutput("addr_r", addr_r, exp_q[0].addr);
            checkOutput("wr_en", wr_en, out_ready);
            if (out_ready) void'(exp_q.pop_front());
         end
      end else begin
         checkOutput("wr_en idle", wr_en, 1'b0);
      end
      if (rstn && in_valid && in_ready) begin
         e.row  = model_row(op, row_a, row_b);
         e.addr = addr_r_in;
         exp_q.push_back(e);
      end
   end

   // Global time limit.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      bit ok;
      int wr0;
      bit seen[7];
      bit pat[5];
      logic [DW-1:0] op_lit[8];
      logic [RW-1:0] ra;
      logic [RW-1:0] rb;

      pat    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      op_lit = '{32'h00000001, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000002,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000003};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valid", out_valid, 1'b0);
      checkOutput("reset wr_en", wr_en, 1'b0);
      checkOutput("reset R", r_out, '0);
      checkOutput("reset addr_r", addr_r, '0);
      checkOutput("reset in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // ADD with two-cycle latency and a single write strobe
      applyStimulus(3'd0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 10'h005);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("latency stage1 out_valid", out_valid, 1'b0);
      @(negedge clk);
      checkOutput("latency out_valid", out_valid, 1'b1);
      checkOutput("add R literal", r_out, pack4(11, 22, 33, 44));
      checkOutput("add addr literal", addr_r, 10'h005);
      checkOutput("add wr_en", wr_en, 1'b1);
      @(negedge clk);
      checkOutput("single write out_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;

      // Every opcode on -2, 3 in lane 0; other lanes exercise independence
      for (int o = 0; o < 8; o++) begin
         checkOutput("model pin", model_lane(3'(o), 32'hFFFFFFFE, 32'd3), op_lit[o]);
         applyStimulus(3'(o), pack4(32'hFFFFFFFE, 32'd100, 32'h12345678, 32'hFFFFFFF9),
                       pack4(32'd3, 32'hFFFFFFCE, 32'h0F0F0F0F, 32'd9), AW'(16 + o));
         in_valid = 1'b0;
         waitOut(ok);
         if (ok) checkOutput("opcode lane0 literal", r_out[31:0], op_lit[o]);
         @(posedge clk);
         #1;
      end

      // Backpressure: five rows streamed while the store side stalls
      wr0 = wr_count;
      fork
         begin
            for (int k = 1; k <= 5; k++)
               applyStimulus(3'(k), pack4(32'(k * 7), 32'(k + 100), 32'hF0F0F0F0, 32'(k)),
                             pack4(32'(k * 3), 32'd5, 32'h0FF00FF0, 32'hFFFFFFFF), AW'(k));
            in_valid = 1'b0;
         end
         begin
            out_ready = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall in_ready", in_ready, 1'b0);
            checkOutput("stall out_valid", out_valid, 1'b1);
            checkOutput("stall addr_r", addr_r, 10'd1);
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall held in_ready", in_ready, 1'b0);
            checkOutput("stall held addr_r", addr_r, 10'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      checkOutput("backpressure write count", 32'(wr_count - wr0), 32'd5);
      checkOutput("backpressure drained", 32'(exp_q.size()), 32'd0);

      // Bubbles: valid pattern 1,0,1,0,1 appears two cycles later
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               in_valid  = pat[k];
               op        = 3'd5;
               row_a     = pack4(32'(k), 32'hAAAA5555, 32'(k << 8), 32'd0);
               row_b     = pack4(32'hFFFF0000, 32'(k), 32'd1, 32'd2);
               addr_r_in = AW'(40 + k);
               @(posedge clk);
               #1;
            end
            in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 7; k++) begin
               @(negedge clk);
               seen[k] = out_valid;
            end
         end
      join
      for (int k = 0; k < 7; k++) begin
         if (k >= 2) checkOutput("bubble out_valid", seen[k], pat[k-2]);
         else checkOutput("bubble lead out_valid", seen[k], 1'b0);
      end
      @(posedge clk);
      #1;

      // Reset while both stages hold rows
      out_ready = 1'b0;
      applyStimulus(3'd0, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 10'd50);
      applyStimulus(3'd1, pack4(9, 9, 9, 9), pack4(4, 4, 4, 4), 10'd51);
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      exp_q.delete();
      checkOutput("async reset out_valid", out_valid, 1'b0);
      checkOutput("async reset wr_en", wr_en, 1'b0);
      checkOutput("async reset R", r_out, '0);
      checkOutput("async reset in_ready", in_ready, 1'b1);
      wr0 = wr_count;
      @(posedge clk);
      #1;
      rstn      = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("no write after reset", 32'(wr_count - wr0), 32'd0);

      // Signed overflow at the lane limits
      applyStimulus(3'd0, pack4(32'h7FFFFFFF, 32'h80000000, 5, 0),
                    pack4(32'd1, 32'hFFFFFFFF, 0, 0), 10'd60);
      in_valid = 1'b0;
      waitOut(ok);
`ifdef SIMD_SATURATE_EN
      if (ok) checkOutput("add overflow high", r_out[31:0], 32'h7FFFFFFF);
      if (ok) checkOutput("add overflow low", r_out[63:32], 32'h80000000);
`else
      if (ok) checkOutput("add overflow high", r_out[31:0], 32'h80000000);
      if (ok) checkOutput("add overflow low", r_out[63:32], 32'h7FFFFFFF);
`endif
      @(posedge clk);
      #1;
      applyStimulus(3'd1, pack4(32'h80000000, 32'h7FFFFFFF, 5, 0),
                    pack4(32'd1, 32'hFFFFFFFF, 0, 0), 10'd61);
      in_valid = 1'b0;
      waitOut(ok);
`ifdef SIMD_SATURATE_EN
      if (ok) checkOutput("sub overflow low", r_out[31:0], 32'h80000000);
      if (ok) checkOutput("sub overflow high", r_out[63:32], 32'h7FFFFFFF);
`else
      if (ok) checkOutput("sub overflow low", r_out[31:0], 32'h7FFFFFFF);
      if (ok) checkOutput("sub overflow high", r_out[63:32], 32'h80000000);
`endif
      @(posedge clk);
      #1;

      // Mixed stream with intermittent store stalls
      wr0 = wr_count;
      fork
         begin
            for (int k = 0; k < 16; k++) begin
               ra = '0;
               rb = '0;
               for (int l = 0; l < NE; l++) begin
                  ra[l*DW +: DW] = 32'(k * 32'h01234567 + l * 32'h10001) ^ 32'(l << 30);
                  rb[l*DW +: DW] = 32'(k * 32'h00F0F0F1 - l * 32'h333);
               end
               applyStimulus(3'(k), ra, rb, AW'(100 + k));
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 30; c++) begin
               out_ready = (c % 3) != 1;
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("stream write count", 32'(wr_count - wr0), 32'd16);
      checkOutput("stream drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
